// File: rtl/sd_spi_arbiter.sv
// sd_spi_arbiter: shares one SD SPI byte engine between two clients, one whole transaction at a time
// Ports:
//   clk, rst                       SD-domain clock, synchronous active-high reset
//   req_i / gnt_o                  per-client lock request / one-hot grant
//   cs_n_in_i                      per-client requested chip-select; only the owner's copy reaches spi_cs_o
//   op_valid_i, op_rx_i            per-client byte op request and kind (1 = receive, sends FF)
//   op_wdata_i                     client n send byte at [8n+7:8n]
//   op_ready_o, rsp_valid_o        owner-only accept and completion pulses
//   rsp_rdata_o                    engine byte captured at completion
//   eng_send_o, eng_recv_o         one-cycle engine strobes
//   eng_din_o, eng_dout_i          bytes to / from the engine
//   eng_ready_i                    engine idle
//   spi_cs_o                       SD chip-select, active-low
//   revoked_o                      pulse when the watchdog takes back an idle grant
module sd_spi_arbiter #(
    parameter bit PRIO0    = 1'b1,
    parameter int HOLD_MAX = 4096,
    parameter int HW       = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_i,
    output logic [1:0]  gnt_o,
    input  logic [1:0]  cs_n_in_i,
    input  logic [1:0]  op_valid_i,
    input  logic [1:0]  op_rx_i,
    input  logic [15:0] op_wdata_i,
    output logic [1:0]  op_ready_o,
    output logic [1:0]  rsp_valid_o,
    output logic [7:0]  rsp_rdata_o,
    output logic        eng_send_o,
    output logic        eng_recv_o,
    output logic [7:0]  eng_din_o,
    input  logic [7:0]  eng_dout_i,
    input  logic        eng_ready_i,
    output logic        spi_cs_o,
    output logic        revoked_o
);
    typedef enum logic [2:0] {IDLE, GRANT, ISSUE, SETTLE, WAITDONE, RELEASE} state_t;
    state_t        state_q, state_d;
    // owner_q keeps its value after release, so it doubles as the last owner for round-robin
    logic          owner_q, rx_q, drop_q;
    logic [1:0]    blk_q;
    logic [HW-1:0] wd_q;
    logic [1:0]    elig, own_hot;
    logic          own_d, own_req, accept, revoke, done, keep, wd_hit;
    logic [7:0]    wbyte;
    // a revoked client stays blocked until it drops req
    assign elig    = req_i & ~blk_q;
    assign own_d   = (elig == 2'b11) ? (PRIO0 ? 1'b0 : ~owner_q) : elig[1];
    assign own_hot = {owner_q, ~owner_q};
    assign own_req = req_i[owner_q];
    assign wbyte   = owner_q ? op_wdata_i[15:8] : op_wdata_i[7:0];
    assign wd_hit  = (HOLD_MAX != 0) && (wd_q == HW'(HOLD_MAX - 1));
    assign accept  = (state_q == GRANT) && own_req && op_valid_i[owner_q] && eng_ready_i;
    assign revoke  = (state_q == GRANT) && own_req && !accept && wd_hit;
    assign done    = (state_q == WAITDONE) && eng_ready_i;
    // an op whose owner let go at any point during it completes silently
    assign keep    = own_req && !drop_q;
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     state_d = (|elig) ? GRANT : IDLE;
            GRANT:    state_d = (!own_req || revoke) ? RELEASE : accept ? ISSUE : GRANT;
            ISSUE:    state_d = SETTLE;
            SETTLE:   state_d = WAITDONE;
            WAITDONE: state_d = !eng_ready_i ? WAITDONE : keep ? GRANT : RELEASE;
            default:  state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= 1'b1;
            rx_q        <= 1'b0;
            drop_q      <= 1'b0;
            blk_q       <= 2'b00;
            wd_q        <= '0;
            gnt_o       <= 2'b00;
            op_ready_o  <= 2'b00;
            rsp_valid_o <= 2'b00;
            rsp_rdata_o <= 8'h00;
            eng_send_o  <= 1'b0;
            eng_recv_o  <= 1'b0;
            eng_din_o   <= 8'hFF;
            spi_cs_o    <= 1'b1;
            revoked_o   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= (state_q == IDLE && |elig) ? own_d : owner_q;
            gnt_o       <= (state_q == IDLE && |elig) ? {own_d, ~own_d} : (state_d == RELEASE) ? 2'b00 : gnt_o;
            rx_q        <= accept ? op_rx_i[owner_q] : rx_q;
            drop_q      <= accept ? 1'b0 : (state_q inside {ISSUE, SETTLE, WAITDONE} && !own_req) ? 1'b1 : drop_q;
            blk_q       <= revoke ? (blk_q | own_hot) : (blk_q & req_i);
            wd_q        <= (state_q == IDLE || accept) ? '0 : (state_q == GRANT) ? wd_q + 1'b1 : wd_q;
            op_ready_o  <= accept ? own_hot : 2'b00;
            rsp_valid_o <= (done && keep) ? own_hot : 2'b00;
            rsp_rdata_o <= done ? eng_dout_i : rsp_rdata_o;
            eng_send_o  <= (state_q == ISSUE) && !rx_q;
            eng_recv_o  <= (state_q == ISSUE) && rx_q;
            eng_din_o   <= accept ? (op_rx_i[owner_q] ? 8'hFF : wbyte) : (state_d == RELEASE) ? 8'hFF : eng_din_o;
            // chip-select lags the owner's request by one cycle and is forced high outside a grant
            spi_cs_o    <= (state_q == IDLE || state_d == RELEASE || state_d == IDLE) ? 1'b1 : cs_n_in_i[owner_q];
            revoked_o   <= revoke;
        end
    end
endmodule

// File: tb/tb_sd_spi_arbiter.sv
// tb_sd_spi_arbiter: checks grant/release, chip-select, byte ops, watchdog and reset of sd_spi_arbiter
module tb_sd_spi_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = 2'b00, cs_n_in = 2'b11, op_valid = 2'b00, op_rx = 2'b00;
    logic [15:0] op_wdata = 16'h0000;
    logic [7:0]  eng_dout;
    logic        eng_ready;
    logic [1:0]  gnt, op_ready, rsp_valid;
    logic [7:0]  rsp_rdata, eng_din;
    logic        eng_send, eng_recv, spi_cs, revoked;
    logic [1:0]  r_gnt, r_op_ready, r_rsp_valid;
    logic [7:0]  r_rsp_rdata, r_eng_din;
    logic        r_eng_send, r_eng_recv, r_spi_cs, r_revoked;
    int          checks = 0, failures = 0;
    int          eng_fix = 0;
    logic [7:0]  eng_next = 8'h00;

    always #5 clk = ~clk;

    sd_spi_arbiter #(.PRIO0(1'b1), .HOLD_MAX(16), .HW(5)) dut (
        .clk(clk), .rst(rst), .req_i(req), .gnt_o(gnt), .cs_n_in_i(cs_n_in),
        .op_valid_i(op_valid), .op_rx_i(op_rx), .op_wdata_i(op_wdata),
        .op_ready_o(op_ready), .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
        .eng_send_o(eng_send), .eng_recv_o(eng_recv), .eng_din_o(eng_din),
        .eng_dout_i(eng_dout), .eng_ready_i(eng_ready), .spi_cs_o(spi_cs), .revoked_o(revoked)
    );

    sd_spi_arbiter #(.PRIO0(1'b0), .HOLD_MAX(0), .HW(12)) dut_rr (
        .clk(clk), .rst(rst), .req_i(req), .gnt_o(r_gnt), .cs_n_in_i(cs_n_in),
        .op_valid_i(op_valid), .op_rx_i(op_rx), .op_wdata_i(op_wdata),
        .op_ready_o(r_op_ready), .rsp_valid_o(r_rsp_valid), .rsp_rdata_o(r_rsp_rdata),
        .eng_send_o(r_eng_send), .eng_recv_o(r_eng_recv), .eng_din_o(r_eng_din),
        .eng_dout_i(eng_dout), .eng_ready_i(eng_ready), .spi_cs_o(r_spi_cs), .revoked_o(r_revoked)
    );

    // engine: busy for a few cycles after any strobe, then presents the prepared byte
    initial begin
        eng_ready = 1'b1;
        eng_dout  = 8'h00;
        forever begin
            @(negedge clk);
            if (eng_send || eng_recv) begin
                eng_ready = 1'b0;
                repeat (eng_fix != 0 ? eng_fix : int'($urandom_range(1, 4))) @(negedge clk);
                eng_dout  = eng_next;
                eng_ready = 1'b1;
            end
        end
    end

    // every-cycle rules: single owner, pulses only to owner, chip-select tracks the owner only
    logic [1:0] pg = 2'b00;
    logic       pc = 1'b1;
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (gnt == 2'b11 || ((op_ready | rsp_valid) & ~gnt) != 2'b00 || (eng_send && eng_recv)) begin
                failures++;
                $display("FAIL mon_owner gnt=%b op_ready=%b rsp_valid=%b send=%b recv=%b", gnt, op_ready, rsp_valid, eng_send, eng_recv);
            end
            if (gnt == 2'b00 || gnt == pg) begin
                checks++;
                if (spi_cs !== ((gnt == 2'b00) ? 1'b1 : pc)) begin
                    failures++;
                    $display("FAIL mon_spi_cs got=%b want=%b gnt=%b", spi_cs, (gnt == 2'b00) ? 1'b1 : pc, gnt);
                end
            end
        end
        pg = gnt;
        pc = cs_n_in[gnt[1]];
    end

    initial begin
        #400000;
        $display("FAIL timeout");
        $fatal(1, "bench timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic wait_gnt(input logic [1:0] g);
        int n = 0;
        while (gnt != g && n < 10) begin
            step();
            n++;
        end
        chk("wait_gnt", gnt, g);
    endtask

    // one byte op by client c; expectations come from the op itself and the engine's prepared byte
    task automatic do_op(input int c, input bit rx, input logic [7:0] b, input logic [7:0] d);
        int n = 0;
        eng_next = d;
        op_valid[c] = 1'b1;
        op_rx[c] = rx;
        op_wdata[8*c +: 8] = b;
        step();
        chk("op_ready", op_ready, 1 << c);
        op_valid[c] = 1'b0;
        op_wdata[8*c +: 8] = 8'($urandom);
        step();
        chk("strobe", {eng_send, eng_recv}, rx ? 2'b01 : 2'b10);
        chk("eng_din", eng_din, rx ? 8'hFF : b);
        while (rsp_valid == 2'b00 && n < 20) begin
            step();
            n++;
        end
        chk("rsp_valid", rsp_valid, 1 << c);
        chk("rsp_rdata", rsp_rdata, d);
        step();
    endtask

    typedef struct {
        logic [1:0] req;
        logic [1:0] cs;
        logic [1:0] g;
        logic [1:0] rg;
        logic       scs;
    } vec_t;
    vec_t tbl[19];

    initial begin
        int n, c, o, nops;
        logic seen, strb;
        tbl[0]  = '{2'b11, 2'b11, 2'b01, 2'b01, 1'b1};
        tbl[1]  = '{2'b11, 2'b10, 2'b01, 2'b01, 1'b0};
        tbl[2]  = '{2'b11, 2'b01, 2'b01, 2'b01, 1'b1};
        tbl[3]  = '{2'b10, 2'b01, 2'b00, 2'b00, 1'b1};
        tbl[4]  = '{2'b10, 2'b01, 2'b00, 2'b00, 1'b1};
        tbl[5]  = '{2'b10, 2'b00, 2'b10, 2'b10, 1'b1};
        tbl[6]  = '{2'b10, 2'b01, 2'b10, 2'b10, 1'b0};
        tbl[7]  = '{2'b10, 2'b00, 2'b10, 2'b10, 1'b0};
        tbl[8]  = '{2'b10, 2'b01, 2'b10, 2'b10, 1'b0};
        tbl[9]  = '{2'b10, 2'b10, 2'b10, 2'b10, 1'b1};
        tbl[10] = '{2'b00, 2'b10, 2'b00, 2'b00, 1'b1};
        tbl[11] = '{2'b00, 2'b10, 2'b00, 2'b00, 1'b1};
        tbl[12] = '{2'b11, 2'b11, 2'b01, 2'b01, 1'b1};
        tbl[13] = '{2'b10, 2'b11, 2'b00, 2'b00, 1'b1};
        tbl[14] = '{2'b11, 2'b11, 2'b00, 2'b00, 1'b1};
        tbl[15] = '{2'b11, 2'b00, 2'b01, 2'b10, 1'b1};
        tbl[16] = '{2'b11, 2'b00, 2'b01, 2'b10, 1'b0};
        tbl[17] = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b1};
        tbl[18] = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b1};

        repeat (3) step();
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_op_ready", op_ready, 2'b00);
        chk("rst_rsp_valid", rsp_valid, 2'b00);
        chk("rst_rsp_rdata", rsp_rdata, 8'h00);
        chk("rst_strobes", {eng_send, eng_recv}, 2'b00);
        chk("rst_eng_din", eng_din, 8'hFF);
        chk("rst_spi_cs", spi_cs, 1'b1);
        chk("rst_revoked", revoked, 1'b0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 19; i++) begin
            req = tbl[i].req;
            cs_n_in = tbl[i].cs;
            step();
            chk($sformatf("tbl%0d_gnt", i), gnt, tbl[i].g);
            chk($sformatf("tbl%0d_rr_gnt", i), r_gnt, tbl[i].rg);
            chk($sformatf("tbl%0d_spi_cs", i), spi_cs, tbl[i].scs);
        end

        cs_n_in = 2'b10;
        req = 2'b01;
        wait_gnt(2'b01);
        do_op(0, 1'b0, 8'h40, 8'($urandom));
        do_op(0, 1'b0, 8'h00, 8'($urandom));
        do_op(0, 1'b0, 8'h95, 8'($urandom));
        do_op(0, 1'b1, 8'h5A, 8'h01);
        chk("seq_gnt", gnt, 2'b01);
        req = 2'b00;
        repeat (3) step();

        for (int t = 0; t < 30; t++) begin
            c = int'($urandom_range(0, 1));
            o = 1 - c;
            nops = int'($urandom_range(1, 3));
            req = 2'b00;
            req[c] = 1'b1;
            op_valid[o] = 1'($urandom);
            op_rx[o] = 1'($urandom);
            op_wdata[8*o +: 8] = 8'($urandom);
            cs_n_in = 2'($urandom);
            wait_gnt(2'b01 << c);
            for (int k = 0; k < nops; k++) begin
                cs_n_in = 2'($urandom);
                do_op(c, 1'($urandom), 8'($urandom), 8'($urandom));
            end
            req = 2'b00;
            op_valid = 2'b00;
            step();
            step();
            chk("rand_release", gnt, 2'b00);
            step();
        end

        cs_n_in = 2'b00;
        req = 2'b01;
        wait_gnt(2'b01);
        n = 0;
        while (gnt == 2'b01 && n < 40) begin
            step();
            n++;
        end
        chk("wd_hold_cycles", n, 16);
        chk("wd_revoked", revoked, 1'b1);
        chk("wd_gnt", gnt, 2'b00);
        chk("wd_spi_cs", spi_cs, 1'b1);
        step();
        chk("wd_pulse_end", revoked, 1'b0);
        repeat (6) step();
        chk("wd_no_regrant", gnt, 2'b00);
        req = 2'b00;
        step();
        req = 2'b01;
        wait_gnt(2'b01);
        req = 2'b00;
        repeat (3) step();

        req = 2'b01;
        wait_gnt(2'b01);
        eng_fix = 6;
        eng_next = 8'hA5;
        op_valid[0] = 1'b1;
        op_rx[0] = 1'b1;
        step();
        op_valid[0] = 1'b0;
        step();
        step();
        req = 2'b00;
        seen = 1'b0;
        strb = 1'b0;
        n = 0;
        while (gnt != 2'b00 && n < 30) begin
            step();
            n++;
            seen |= |rsp_valid;
            strb |= eng_send | eng_recv;
        end
        chk("drop_no_rsp", seen, 1'b0);
        chk("drop_no_strobe", strb, 1'b0);
        chk("drop_gnt", gnt, 2'b00);
        chk("drop_eng_ready", eng_ready, 1'b1);
        chk("drop_held_until_done", n >= 5, 1'b1);
        eng_fix = 0;
        repeat (2) step();

        cs_n_in = 2'b00;
        req = 2'b01;
        wait_gnt(2'b01);
        eng_fix = 3;
        op_valid[0] = 1'b1;
        op_rx[0] = 1'b0;
        op_wdata[7:0] = 8'h3C;
        step();
        op_valid[0] = 1'b0;
        step();
        chk("settle_strobe", eng_send, 1'b1);
        chk("settle_spi_cs", spi_cs, 1'b0);
        rst = 1'b1;
        req = 2'b00;
        step();
        chk("rst_mid_gnt", gnt, 2'b00);
        chk("rst_mid_spi_cs", spi_cs, 1'b1);
        chk("rst_mid_op_ready", op_ready, 2'b00);
        chk("rst_mid_rsp_valid", rsp_valid, 2'b00);
        rst = 1'b0;
        n = 0;
        while (!eng_ready && n < 20) begin
            step();
            n++;
        end
        chk("rst_mid_eng_done", eng_ready, 1'b1);
        eng_fix = 0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
